// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch stage: reset/NOP words, PC stride,
// word-alignment mask and the per-edge fetch action encoding.
package fetch_pkg;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCREMENT     = 32'd4;
  localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    FETCH_ADVANCE  = 2'b00,
    FETCH_REDIRECT = 2'b01,
    FETCH_HOLD     = 2'b10
  } fetch_action_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_pc_register.sv
// Program counter flop: holds, loads a word-aligned redirect target, or advances
// by one word. Also exposes the incremented value for the IF/ID register.
module pc_register
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  fetch_action_t action,
  input  logic [31:0]   target,
  output logic [31:0]   pc,
  output logic [31:0]   pc_plus4
);

  logic [31:0] pc_next;

  // Modulo-2^32 add: the top word wraps to address zero.
  assign pc_plus4 = pc + PC_INCREMENT;

  always_comb begin
    pc_next = pc;
    case (action)
      FETCH_ADVANCE:  pc_next = pc_plus4;
      FETCH_REDIRECT: pc_next = align_word(target);
      FETCH_HOLD:     pc_next = pc;
      default:        pc_next = pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= align_word(RESET_PC);
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: PC drives the instruction memory, returned word and PC+4 are
// captured into IF/ID. Stall freezes everything; redirect inserts one bubble.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP      = NOP_WORD
) (
  input  logic        Clk_in,
  input  logic        Rst_n,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] ImemAddress,
  input  logic [31:0] ImemInstruction,
  output logic [31:0] IfIdInstruction,
  output logic [31:0] IfIdPcPlus4,
  output logic        IfIdValid,
  output logic [31:0] FetchCount
);

  fetch_action_t action;
  logic [31:0]   pc;
  logic [31:0]   pc_plus4;

  // Stall outranks redirect; decode keeps Redirect up until the stall clears.
  always_comb begin
    action = FETCH_ADVANCE;
    if (Stall) begin
      action = FETCH_HOLD;
    end else if (Redirect) begin
      action = FETCH_REDIRECT;
    end
  end

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk      (Clk_in),
    .rst_n    (Rst_n),
    .action   (action),
    .target   (RedirectTarget),
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

  assign ImemAddress = pc;

  always_ff @(posedge Clk_in or negedge Rst_n) begin
    if (!Rst_n) begin
      IfIdInstruction <= NOP;
      IfIdPcPlus4     <= 32'd0;
      IfIdValid       <= 1'b0;
    end else begin
      case (action)
        FETCH_ADVANCE: begin
          IfIdInstruction <= ImemInstruction;
          IfIdPcPlus4     <= pc_plus4;
          IfIdValid       <= 1'b1;
        end
        // The word fetched this cycle is on the wrong path; drop it.
        FETCH_REDIRECT: begin
          IfIdInstruction <= NOP;
          IfIdPcPlus4     <= 32'd0;
          IfIdValid       <= 1'b0;
        end
        default: begin
          IfIdInstruction <= IfIdInstruction;
          IfIdPcPlus4     <= IfIdPcPlus4;
          IfIdValid       <= IfIdValid;
        end
      endcase
    end
  end

  always_ff @(posedge Clk_in or negedge Rst_n) begin
    if (!Rst_n) begin
      FetchCount <= 32'd0;
    end else if (action == FETCH_ADVANCE) begin
      FetchCount <= FetchCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a 64-word combinational memory
// preloaded with mem[i] = i*3.
module tb_instruction_fetch_unit;

  logic        Clk_in;
  logic        Rst_n;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic [31:0] ImemAddress;
  logic [31:0] ImemInstruction;
  logic [31:0] IfIdInstruction;
  logic [31:0] IfIdPcPlus4;
  logic        IfIdValid;
  logic [31:0] FetchCount;

  logic [31:0] mem [64];
  int          n_tests;
  int          n_fail;

  instruction_fetch_unit dut (
    .Clk_in          (Clk_in),
    .Rst_n           (Rst_n),
    .Stall           (Stall),
    .Redirect        (Redirect),
    .RedirectTarget  (RedirectTarget),
    .ImemAddress     (ImemAddress),
    .ImemInstruction (ImemInstruction),
    .IfIdInstruction (IfIdInstruction),
    .IfIdPcPlus4     (IfIdPcPlus4),
    .IfIdValid       (IfIdValid),
    .FetchCount      (FetchCount)
  );

  assign ImemInstruction = mem[ImemAddress[7:2]];

  initial Clk_in = 1'b0;
  always #5 Clk_in = ~Clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk_in);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                         input logic [31:0] pc4, input logic valid, input logic [31:0] cnt);
    chk({tag, ".addr"},  ImemAddress,     addr);
    chk({tag, ".instr"}, IfIdInstruction, instr);
    chk({tag, ".pc4"},   IfIdPcPlus4,     pc4);
    chk({tag, ".valid"}, {31'd0, IfIdValid}, {31'd0, valid});
    chk({tag, ".count"}, FetchCount,      cnt);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 64; i++) mem[i] = i * 3;
    Rst_n          = 1'b0;
    Stall          = 1'b0;
    Redirect       = 1'b0;
    RedirectTarget = 32'd0;

    #2;
    chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    #6 Rst_n = 1'b1;

    // Free-running: first two fetches, PC ends at 0x8
    step(); chk_all("run0", 32'h4, 32'd0, 32'd4, 1'b1, 32'd1);
    step(); chk_all("run1", 32'h8, 32'd3, 32'd8, 1'b1, 32'd2);

    // Stall three edges at PC 0x8
    Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); chk_all("stall", 32'h8, 32'd3, 32'd8, 1'b1, 32'd2);
    end
    Stall = 1'b0;
    step(); chk_all("run2", 32'hC,  32'd6, 32'd12, 1'b1, 32'd3);
    step(); chk_all("run3", 32'h10, 32'd9, 32'd16, 1'b1, 32'd4);

    // Redirect to unaligned 0x43 -> 0x40, one bubble, then mem[16]
    Redirect = 1'b1; RedirectTarget = 32'h43;
    step(); chk_all("redir", 32'h40, 32'd0, 32'd0, 1'b0, 32'd4);
    Redirect = 1'b0;
    step(); chk_all("redir_tgt", 32'h44, 32'd48, 32'h44, 1'b1, 32'd5);

    // Stall and redirect together: stall wins, redirect taken once stall drops
    Stall = 1'b1; Redirect = 1'b1; RedirectTarget = 32'h80;
    step(); chk_all("stall_redir", 32'h44, 32'd48, 32'h44, 1'b1, 32'd5);
    Stall = 1'b0;
    step(); chk_all("late_redir", 32'h80, 32'd0, 32'd0, 1'b0, 32'd5);
    Redirect = 1'b0;
    step(); chk_all("late_tgt", 32'h84, 32'd96, 32'h84, 1'b1, 32'd6);

    // Wrap: PC at top word, next fetch wraps address and PC+4 to zero
    Redirect = 1'b1; RedirectTarget = 32'hFFFF_FFFF;
    step(); chk_all("wrap_redir", 32'hFFFF_FFFC, 32'd0, 32'd0, 1'b0, 32'd6);
    Redirect = 1'b0;
    step(); chk_all("wrap", 32'h0, 32'd189, 32'h0, 1'b1, 32'd7);
    step(); chk_all("post_wrap", 32'h4, 32'd0, 32'h4, 1'b1, 32'd8);

    // Asynchronous reset between edges while a redirect is pending
    Redirect = 1'b1; RedirectTarget = 32'h20;
    #2 Rst_n = 1'b0;
    #1 chk_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    #1 Rst_n = 1'b1;
    Redirect = 1'b0;
    step(); chk_all("after_rst", 32'h4, 32'd0, 32'd4, 1'b1, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage of the MIPS pipeline: owns the program counter, drives the word address into the combinational instruction memory, and latches the returned instruction together with PC+4 into the IF/ID pipeline register. Supports load-use stall (hold), branch/jump redirect with one-slot flush, and a retired-fetch counter for debug. Sits directly upstream of the instruction memory and feeds the decode stage.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_WORD, 32'h0000_0000, word inserted into IF/ID on flush/reset (sll $0,$0,0)

Ports:
- Clk_in  input  1  rising-edge clock (one clock domain)
- Rst_n  input  1  reset, asynchronous, active-low
- Stall  input  1  hazard unit hold request; freezes PC, IF/ID, counter
- Redirect  input  1  branch taken / jump from decode; valid for one cycle
- RedirectTarget  input  32  new PC when Redirect=1
- ImemAddress  output  32  current PC, to instruction memory Address
- ImemInstruction  input  32  instruction memory read data (combinational from ImemAddress)
- IfIdInstruction  output  32  registered instruction to decode
- IfIdPcPlus4  output  32  registered PC+4 of that instruction
- IfIdValid  output  1  1 = IF/ID holds a real instruction, 0 = bubble
- FetchCount  output  32  number of valid instructions latched since reset

## Operation
- PC register drives ImemAddress directly; no other logic on the address path.
- Next-state priority each rising edge (highest first):
  - Stall=1: PC, IfIdInstruction, IfIdPcPlus4, IfIdValid, FetchCount all hold. Redirect ignored; decode keeps Redirect asserted until Stall drops.
  - Redirect=1: PC ← {RedirectTarget[31:2], 2'b00}; IfIdInstruction ← NOP_WORD, IfIdPcPlus4 ← 0, IfIdValid ← 0 (wrong-path fetch discarded); FetchCount holds.
  - otherwise: PC ← PC + 4; IfIdInstruction ← ImemInstruction; IfIdPcPlus4 ← PC + 4; IfIdValid ← 1; FetchCount ← FetchCount + 1.
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC + 4 = 32'h0. FetchCount wraps at 2^32 silently.
- RedirectTarget bits [1:0] always forced to 0; PC is always word-aligned.
- Memory aliasing beyond the memory index range is the memory's concern; fetch does not range-check.

## Timing
- Reset (Rst_n=0, asynchronous, no clock needed): PC=RESET_PC, IfIdInstruction=NOP_WORD, IfIdPcPlus4=0, IfIdValid=0, FetchCount=0. ImemAddress=RESET_PC immediately.
- First rising edge after Rst_n rises with Stall=0, Redirect=0: IF/ID = mem[RESET_PC], IfIdPcPlus4=RESET_PC+4, IfIdValid=1, PC=RESET_PC+4.
- Fetch latency: instruction at PC appears on IfIdInstruction one edge later. Throughput one instruction/cycle when unstalled.
- Redirect penalty: exactly one bubble (IfIdValid=0 for one cycle); target instruction valid on IF/ID two edges after Redirect sampled.
- Stall and Redirect same edge: stall wins, nothing changes.
- Rst_n asserted mid-stall or mid-redirect: all state to reset values asynchronously; pending redirect lost.

## Structure
- Shared package fetch_pkg: NOP_WORD, RESET_PC default, PC_INCREMENT (32'd4), word-alignment mask.
- One sub-module natural: pc_register (PC flop with async active-low reset, hold, load-target, increment). IF/ID register and counter live in the top.

## Test plan
- Reset then 4 free-running cycles, memory preloaded mem[i]=i*3 → IfIdInstruction 0,3,6,9; IfIdPcPlus4 4,8,12,16; FetchCount=4.
- Stall high 3 cycles at PC=0x8 → ImemAddress stays 0x8, IF/ID and FetchCount unchanged; resumes with mem[2] next edge.
- Redirect=1, RedirectTarget=0x43 at PC=0x10 → PC=0x40, IfIdValid=0 and IfIdInstruction=0 one cycle, then mem[16] valid.
- Stall=1 and Redirect=1 same edge → no state change; Redirect held, Stall dropped → redirect taken next edge.
- PC forced to 0xFFFF_FFFC via redirect, one free cycle → PC=0x0, IfIdPcPlus4=0x0.
- Rst_n pulsed low between clock edges during redirect → outputs at reset values before next edge, ImemAddress=RESET_PC.
